// File: rtl/paralelo_serial_tx.sv
// Transmit-side parallel-to-serial converter: 4 lanes x 8 bits, MSB first, one bit per clk.
// COM fills invalid lanes and the post-reset sync preamble.
module paralelo_serial_tx #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned SYNC_COM = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic       word_ready,
  output logic       data_out,
  output logic       tx_active
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COM - 1);

  state_t     state;
  logic [7:0] sreg;
  logic [2:0] bit_cnt;
  logic [1:0] lane_cnt;
  logic [3:0] sync_cnt;
  logic [7:0] hold_data [4];
  logic [3:0] hold_valid;
  logic [7:0] lane0_byte;

  assign data_out   = sreg[7];
  assign lane0_byte = valid0 ? data_in0 : COM;

  // Capture edge: last bit of the final sync COM, or last bit of lane 3.
  always_comb begin
    word_ready = 1'b0;
    if (bit_cnt == 3'd7) begin
      word_ready = ((state == SYNC)   && (sync_cnt == SYNC_LAST)) ||
                   ((state == ACTIVE) && (lane_cnt == 2'd0));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      sreg       <= COM;
      bit_cnt    <= '0;
      lane_cnt   <= '0;
      sync_cnt   <= '0;
      tx_active  <= 1'b0;
      hold_valid <= '0;
      for (int unsigned i = 0; i < 4; i++) hold_data[i] <= '0;
    end else if (bit_cnt != 3'd7) begin
      sreg    <= {sreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end else begin
      bit_cnt <= '0;
      if (word_ready) begin
        // Lane 0 bypasses the hold registers so its MSB is out the cycle after capture.
        hold_data[0] <= data_in0;
        hold_data[1] <= data_in1;
        hold_data[2] <= data_in2;
        hold_data[3] <= data_in3;
        hold_valid   <= {valid3, valid2, valid1, valid0};
        sreg         <= lane0_byte;
        lane_cnt     <= 2'd1;
        state        <= ACTIVE;
        tx_active    <= 1'b1;
      end else if (state == SYNC) begin
        sreg     <= COM;
        sync_cnt <= sync_cnt + 4'd1;
      end else begin
        sreg     <= hold_valid[lane_cnt] ? hold_data[lane_cnt] : COM;
        lane_cnt <= lane_cnt + 2'd1;
      end
    end
  end

endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Transmit-side parallel-to-serial converter for the physical-layer datapath. It accepts 4-lane x 8-bit words with per-lane valids, for example from the recirculator's active path after the mux stage, and emits one serial bit per `clk`, MSB first. Lane bytes go out in order 0..3. The COM symbol (0xBC) is sent for every invalid lane and during link synchronisation, which is what lets the serial-to-parallel receiver detect IDLE and frame bytes.

## Interface
- `COM`, 8'hBC, symbol sent for sync and for invalid lanes
- `SYNC_COM`, 4, number of complete COM bytes sent after reset before data is accepted (range 1..15)
- `clk`  input  1  bit clock; one serial bit per rising edge
- `reset`  input  1  asynchronous, active-high reset
- `data_in0`..`data_in3`  input  8 each  lane bytes, sampled only on the `word_ready` edge
- `valid0`..`valid3`  input  1 each  lane valid, sampled with the data
- `word_ready`  output  1  high for one cycle; inputs are captured on the rising edge that ends this cycle
- `data_out`  output  1  serial stream, MSB first
- `tx_active`  output  1  high once sync is complete and data slots are running

## Operation
- Registers:
  - `sreg[7:0]` shift register; `data_out` = `sreg[7]` directly.
  - `bit_cnt[2:0]`, `lane_cnt[1:0]`, `sync_cnt[3:0]`.
  - `hold_data` (4x8), `hold_valid` (4).
  - `state` in {SYNC, ACTIVE}.
- Reset values (applied asynchronously):
  - `sreg` = COM, so `data_out` = 1.
  - `bit_cnt` = 0, `lane_cnt` = 0, `sync_cnt` = 0.
  - `state` = SYNC, `tx_active` = 0, `word_ready` = 0.
  - `hold_valid` = 0.
- Every edge with `bit_cnt` < 7: `sreg` <= `sreg` << 1 and `bit_cnt` increments.
- Edge with `bit_cnt` == 7 (byte boundary): `bit_cnt` wraps to 0 and `sreg` loads the next byte.
- SYNC state:
  - Each boundary reloads COM and increments `sync_cnt`.
  - On the boundary where `sync_cnt` == `SYNC_COM`-1:
    - `state` <= ACTIVE and `tx_active` <= 1.
    - Inputs are captured into the hold registers.
    - `sreg` loads lane 0: `data_in0` if `valid0`, else COM.
    - `lane_cnt` <= 1.
- ACTIVE state, at each boundary:
  - If `lane_cnt` != 0: `sreg` loads lane `lane_cnt` (`hold_data` if `hold_valid`, else COM); `lane_cnt` increments.
  - If `lane_cnt` == 0 (wrapped after lane 3): a new word is captured and lane 0 is loaded directly from the inputs, as at the end of SYNC.
- `word_ready` is combinational:
  - = (`bit_cnt` == 7) and ((SYNC and `sync_cnt` == `SYNC_COM`-1) or (ACTIVE and `lane_cnt` == 0)).
- Inputs are ignored outside the `word_ready` edge; there is no backpressure.
- Data bytes are sent verbatim. A valid byte equal to 0xBC is indistinguishable from idle at the receiver. That value is reserved and the sender must not present it as valid.
- `tx_active` stays 1 until reset. There is no return to SYNC except through reset.

## Timing
- Cycle 0 is the first cycle after `reset` deasserts; `data_out` during cycle 0 is bit 7 of the first COM.
- With `SYNC_COM`=4:
  - COM occupies cycles 0..31.
  - `word_ready` is high in cycle 31.
  - Lane 0 MSB appears in cycle 32; lanes 1, 2, 3 start at cycles 40, 48, 56.
  - Next `word_ready` is in cycle 63. Period is 32 cycles, continuous, with no gap bits.
- Capture-to-first-bit latency is 0 cycles: the first bit is visible in the cycle right after the capture edge.
- `tx_active` rises at the start of cycle 32, the same edge that loads lane 0.
- Reset mid-operation:
  - Mid-byte or mid-word: `data_out` = 1, `tx_active` = 0 and `word_ready` = 0 immediately, without waiting for a clock edge.
  - The held word is discarded.
  - After release, the full SYNC sequence repeats.
- Reset released coincident with a `clk` edge: that edge is treated as still in reset, and cycle 0 starts at the next edge.

## Test plan
1. **Idle stream.** Reset, then all `valid`=0 → `data_out` repeats 10111100 continuously; `tx_active` rises at cycle 32; `word_ready` pulses at cycles 31, 63, 95.
2. **Full word.** At the first `word_ready`, data 00, 0E, 0E, 4E, all valid → cycles 32..63 carry 00000000 00001110 00001110 01001110, then COM.
3. **Partial valid.** Data C0, 8E, 8E, 0A with `valid1`=0 → byte slots read C0, BC, 8E, 0A.
4. **Input churn.** Data and valids change every cycle between `word_ready` pulses → the serial output matches only the values present on the `word_ready` edges.
5. **Back-to-back words.** Word A then word B on consecutive pulses → 64 contiguous bits, A lanes 0..3 then B lanes 0..3, with no COM between.
6. **Mid-word reset.** `reset` asserted during the lane 2 byte (cycle 50) → immediately `data_out`=1, `tx_active`=0, `word_ready`=0; after release, 32 cycles of COM, then `word_ready` at cycle 31.
